// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM.
// Byte-strobe writes use a one-cycle read-modify-write.
module ram_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic                p0_req_we,
    input  logic [ADDR_W-1:0]   p0_req_addr,
    input  logic [DATA_W-1:0]   p0_req_wdata,
    input  logic [DATA_W/8-1:0] p0_req_wstrb,
    output logic                p0_resp_valid,
    output logic [DATA_W-1:0]   p0_resp_rdata,
    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic                p1_req_we,
    input  logic [ADDR_W-1:0]   p1_req_addr,
    input  logic [DATA_W-1:0]   p1_req_wdata,
    input  logic [DATA_W/8-1:0] p1_req_wstrb,
    output logic                p1_resp_valid,
    output logic [DATA_W-1:0]   p1_resp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wr,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int SW = DATA_W / 8;

    typedef enum logic {S_IDLE, S_RMW} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              p0_rv_q, p0_rv_d, p1_rv_q, p1_rv_d;
    logic [DATA_W-1:0] p0_rd_q, p0_rd_d, p1_rd_q, p1_rd_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
    logic [SW-1:0]     rmw_wstrb_q, rmw_wstrb_d;
    logic              rmw_port_q, rmw_port_d;
    logic [DATA_W-1:0] rmw_old_q, rmw_old_d;

    logic              p0_win, p1_win;
    logic              rdy0, rdy1, wr_int;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, merged, resp_data;
    logic [SW-1:0]     sel_wstrb;
    logic              resp_fire, resp_port;

    // last_grant_q==1 means port 1 won last, so port 0 wins contention
    always_comb begin
        p0_win = 1'b0;
        p1_win = 1'b0;
        if (p0_req_valid && p1_req_valid) begin
            if (PRIO_MODE == 1) p0_win = 1'b1;
            else begin
                p0_win = last_grant_q;
                p1_win = ~last_grant_q;
            end
        end else begin
            p0_win = p0_req_valid;
            p1_win = p1_req_valid;
        end
    end

    assign sel_we    = p1_win ? p1_req_we    : p0_req_we;
    assign sel_addr  = p1_win ? p1_req_addr  : p0_req_addr;
    assign sel_wdata = p1_win ? p1_req_wdata : p0_req_wdata;
    assign sel_wstrb = p1_win ? p1_req_wstrb : p0_req_wstrb;

    always_comb begin
        merged = rmw_old_q;
        for (int i = 0; i < SW; i++) begin
            if (rmw_wstrb_q[i]) merged[8*i +: 8] = rmw_wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_wdata_d  = rmw_wdata_q;
        rmw_wstrb_d  = rmw_wstrb_q;
        rmw_port_d   = rmw_port_q;
        rmw_old_d    = rmw_old_q;
        mem_addr     = '0;
        mem_wdata    = '0;
        wr_int       = 1'b0;
        rdy0         = 1'b0;
        rdy1         = 1'b0;
        resp_fire    = 1'b0;
        resp_port    = 1'b0;
        resp_data    = '0;
        unique case (state_q)
            S_IDLE: begin
                rdy0 = p0_win;
                rdy1 = p1_win;
                if (p0_win || p1_win) begin
                    mem_addr     = sel_addr;
                    last_grant_d = p1_win;
                    resp_port    = p1_win;
                    resp_fire    = 1'b1;
                    resp_data    = mem_rdata;
                    if (sel_we && (&sel_wstrb)) begin
                        wr_int    = 1'b1;
                        mem_wdata = sel_wdata;
                        resp_data = sel_wdata;
                    end else if (sel_we && (|sel_wstrb)) begin
                        resp_fire   = 1'b0;
                        state_d     = S_RMW;
                        rmw_addr_d  = sel_addr;
                        rmw_wdata_d = sel_wdata;
                        rmw_wstrb_d = sel_wstrb;
                        rmw_port_d  = p1_win;
                        rmw_old_d   = mem_rdata;
                    end
                end
            end
            S_RMW: begin
                mem_addr  = rmw_addr_q;
                mem_wdata = merged;
                wr_int    = 1'b1;
                resp_fire = 1'b1;
                resp_port = rmw_port_q;
                resp_data = merged;
                state_d   = S_IDLE;
            end
        endcase
        p0_rv_d = resp_fire && !resp_port;
        p1_rv_d = resp_fire && resp_port;
        p0_rd_d = p0_rv_d ? resp_data : p0_rd_q;
        p1_rd_d = p1_rv_d ? resp_data : p1_rd_q;
    end

    // Gated so a reset landing mid-RMW can never corrupt RAM
    assign mem_wr       = rst_n & wr_int;
    assign p0_req_ready = rst_n & rdy0;
    assign p1_req_ready = rst_n & rdy1;

    assign p0_resp_valid = p0_rv_q;
    assign p1_resp_valid = p1_rv_q;
    assign p0_resp_rdata = p0_rd_q;
    assign p1_resp_rdata = p1_rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            p0_rv_q      <= 1'b0;
            p1_rv_q      <= 1'b0;
            p0_rd_q      <= '0;
            p1_rd_q      <= '0;
            rmw_addr_q   <= '0;
            rmw_wdata_q  <= '0;
            rmw_wstrb_q  <= '0;
            rmw_port_q   <= 1'b0;
            rmw_old_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            p0_rv_q      <= p0_rv_d;
            p1_rv_q      <= p1_rv_d;
            p0_rd_q      <= p0_rd_d;
            p1_rd_q      <= p1_rd_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_wdata_q  <= rmw_wdata_d;
            rmw_wstrb_q  <= rmw_wstrb_d;
            rmw_port_q   <= rmw_port_d;
            rmw_old_q    <= rmw_old_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: round-robin instance with a RAM
// model, plus a fixed-priority instance for arbitration only.
module tb_ram_arbiter;
    logic        clk;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [12:0] p0_req_addr;
    logic [31:0] p0_req_wdata;
    logic [3:0]  p0_req_wstrb;
    logic        p0_resp_valid;
    logic [31:0] p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [12:0] p1_req_addr;
    logic [31:0] p1_req_wdata;
    logic [3:0]  p1_req_wstrb;
    logic        p1_resp_valid;
    logic [31:0] p1_resp_rdata;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wr;

    logic        f_p0_valid, f_p0_ready, f_p0_rv;
    logic        f_p1_valid, f_p1_ready, f_p1_rv;
    logic [31:0] f_p0_rd, f_p1_rd, f_mem_wdata, f_mem_rdata;
    logic [12:0] f_mem_addr;
    logic        f_mem_wr;

    logic [31:0] ram [0:8191];
    logic        pl_en;
    logic [12:0] pl_addr;
    logic [31:0] pl_data;

    int errors;
    int checks;

    ram_arbiter #(.ADDR_W(13), .DATA_W(32), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    ram_arbiter #(.ADDR_W(13), .DATA_W(32), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(f_p0_valid), .p0_req_ready(f_p0_ready),
        .p0_req_we(1'b0), .p0_req_addr(13'h001),
        .p0_req_wdata(32'h0), .p0_req_wstrb(4'h0),
        .p0_resp_valid(f_p0_rv), .p0_resp_rdata(f_p0_rd),
        .p1_req_valid(f_p1_valid), .p1_req_ready(f_p1_ready),
        .p1_req_we(1'b0), .p1_req_addr(13'h002),
        .p1_req_wdata(32'h0), .p1_req_wstrb(4'h0),
        .p1_resp_valid(f_p1_rv), .p1_resp_rdata(f_p1_rd),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_wr(f_mem_wr), .mem_rdata(f_mem_rdata)
    );

    assign f_mem_rdata = 32'h0;
    assign mem_rdata   = ram[mem_addr];

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wr) ram[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic preload(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 13'h100;
        p0_req_wdata = 32'h0; p0_req_wstrb = 4'hF;
        #1;
        checks++;
        if (p0_req_ready !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_gate: ready=%b mem_wr=%b exp 0 0", p0_req_ready, mem_wr);
        end
        checks++;
        if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0 || p0_resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: rv0=%b rv1=%b rd0=%h exp 0 0 0", p0_resp_valid, p1_resp_valid, p0_resp_rdata);
        end
        p0_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        preload(13'h100, 32'h5555AAAA);
        // read handshake, then reset asynchronously while its response is up
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b0;
        @(negedge clk);
        p0_req_we = 1'b1; p0_req_wdata = 32'h0BAD0BAD;
        #1;
        checks++;
        if (p0_resp_valid !== 1'b1 || p0_req_ready !== 1'b1 || mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rv=%b rdy=%b wr=%b exp 1 1 1", p0_resp_valid, p0_req_ready, mem_wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (p0_resp_valid !== 1'b0 || p0_req_ready !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rv=%b rdy=%b wr=%b exp 0 0 0", p0_resp_valid, p0_req_ready, mem_wr);
        end
        @(negedge clk);
        p0_req_valid = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (ram[13'h100] !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL reset_nowrite: ram=%h exp 5555aaaa", ram[13'h100]);
        end
    endtask

    task automatic test_read();
        preload(13'h010, 32'hDEADBEEF);
        @(negedge clk);
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 13'h010;
        #1;
        checks++;
        if (p1_req_ready !== 1'b1 || mem_addr !== 13'h010 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: rdy=%b addr=%h wr=%b exp 1 010 0", p1_req_ready, mem_addr, mem_wr);
        end
        @(negedge clk);
        p1_req_valid = 1'b0;
        checks++;
        if (p1_resp_valid !== 1'b1 || p1_resp_rdata !== 32'hDEADBEEF || p0_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_resp: rv1=%b rd=%h rv0=%b exp 1 deadbeef 0", p1_resp_valid, p1_resp_rdata, p0_resp_valid);
        end
        @(negedge clk);
        checks++;
        if (p1_resp_valid !== 1'b0 || mem_addr !== 13'h0 || mem_wdata !== 32'h0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL idle: rv1=%b addr=%h wd=%h wr=%b exp 0 0 0 0", p1_resp_valid, mem_addr, mem_wdata, mem_wr);
        end
    endtask

    task automatic test_partial_write();
        preload(13'h020, 32'hAABBCCDD);
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 13'h020;
        p0_req_wdata = 32'h11223344; p0_req_wstrb = 4'b0101;
        #1;
        checks++;
        if (p0_req_ready !== 1'b1 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL rmw_grant: rdy=%b wr=%b exp 1 0", p0_req_ready, mem_wr);
        end
        @(negedge clk);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 13'h010;
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 13'h020 || mem_wdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rmw_write: wr=%b addr=%h wd=%h exp 1 020 aa22cc44", mem_wr, mem_addr, mem_wdata);
        end
        checks++;
        if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0 || p0_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_stall: rdy0=%b rdy1=%b rv0=%b exp 0 0 0", p0_req_ready, p1_req_ready, p0_resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (p0_resp_valid !== 1'b1 || p0_resp_rdata !== 32'hAA22CC44 || ram[13'h020] !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rmw_ack: rv=%b rd=%h ram=%h exp 1 aa22cc44 aa22cc44", p0_resp_valid, p0_resp_rdata, ram[13'h020]);
        end
        checks++;
        if (p1_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: rdy1=%b exp 1", p1_req_ready);
        end
        @(negedge clk);
        p1_req_valid = 1'b0;
        checks++;
        if (p1_resp_valid !== 1'b1 || p1_resp_rdata !== 32'hDEADBEEF || p0_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_resp: rv1=%b rd=%h rv0=%b exp 1 deadbeef 0", p1_resp_valid, p1_resp_rdata, p0_resp_valid);
        end
    endtask

    task automatic test_full_write();
        preload(13'h040, 32'h01020304);
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 13'h040;
        p0_req_wdata = 32'hCAFEF00D; p0_req_wstrb = 4'hF;
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL full_write: wr=%b wd=%h exp 1 cafef00d", mem_wr, mem_wdata);
        end
        @(negedge clk);
        p0_req_wdata = 32'h0; p0_req_wstrb = 4'h0;
        #1;
        checks++;
        if (p0_resp_valid !== 1'b1 || p0_resp_rdata !== 32'hCAFEF00D || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL full_ack: rv=%b rd=%h wr=%b exp 1 cafef00d 0", p0_resp_valid, p0_resp_rdata, mem_wr);
        end
        @(negedge clk);
        p0_req_valid = 1'b0;
        checks++;
        if (p0_resp_valid !== 1'b1 || p0_resp_rdata !== 32'hCAFEF00D || ram[13'h040] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL zero_strb: rv=%b rd=%h ram=%h exp 1 cafef00d cafef00d", p0_resp_valid, p0_resp_rdata, ram[13'h040]);
        end
    endtask

    task automatic test_round_robin();
        logic exp0;
        apply_reset();
        p0_req_we = 1'b0; p0_req_addr = 13'h010;
        p1_req_we = 1'b0; p1_req_addr = 13'h020;
        p0_req_valid = 1'b1; p1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp0 = (k % 2 == 0);
            #1;
            checks++;
            if (p0_req_ready !== exp0 || p1_req_ready !== !exp0) begin
                errors++;
                $display("FAIL rr_grant%0d: rdy0=%b rdy1=%b exp %b %b", k, p0_req_ready, p1_req_ready, exp0, !exp0);
            end
            @(negedge clk);
            checks++;
            if (p0_resp_valid !== exp0 || p1_resp_valid !== !exp0) begin
                errors++;
                $display("FAIL rr_resp%0d: rv0=%b rv1=%b exp %b %b", k, p0_resp_valid, p1_resp_valid, exp0, !exp0);
            end
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        f_p0_valid = 1'b1; f_p1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (f_p0_ready !== 1'b1 || f_p1_ready !== 1'b0) begin
                errors++;
                $display("FAIL fp_grant%0d: rdy0=%b rdy1=%b exp 1 0", k, f_p0_ready, f_p1_ready);
            end
            @(negedge clk);
        end
        f_p0_valid = 1'b0; f_p1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_rmw();
        preload(13'h030, 32'h12345678);
        @(negedge clk);
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 13'h030;
        p1_req_wdata = 32'hFFFFFFFF; p1_req_wstrb = 4'b0011;
        @(negedge clk);
        p1_req_valid = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'h1234FFFF) begin
            errors++;
            $display("FAIL rmw2_pre: wr=%b wd=%h exp 1 1234ffff", mem_wr, mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL rmw2_gate: wr=%b exp 0", mem_wr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ram[13'h030] !== 32'h12345678) begin
            errors++;
            $display("FAIL rmw2_ram: ram=%h exp 12345678", ram[13'h030]);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (p1_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmw2_noresp%0d: rv1=%b exp 0", k, p1_resp_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0;
        p0_req_wdata = '0; p0_req_wstrb = '0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0;
        p1_req_wdata = '0; p1_req_wstrb = '0;
        f_p0_valid = 1'b0; f_p1_valid = 1'b0;
        test_reset();
        test_read();
        test_partial_write();
        test_full_write();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
